// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the OCM dcache data-port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  // One-hot encode a requester index, or all-zero when not valid.
  function automatic logic [1:0] onehot2(input logic valid, input logic idx);
    if (!valid) begin
      return 2'b00;
    end
    return (idx == REQ_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register of read tags with synchronous clear; the tag
// leaving the last stage lines up with the returning read data.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    clear,
  input  rd_tag_t push_tag,
  output rd_tag_t pop_tag
);

  rd_tag_t stage [DEPTH];

  // Shift tags one stage per cycle; clear drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the OCM dcache data port. Requester 0 is the core
// data path, requester 1 an auxiliary loader. Grant is combinational in the
// request cycle; read data is routed back to its issuer after RD_LAT cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [1:0]        lock_i,
  input  logic [2*XLEN-1:0] addr_i,
  input  logic [2*XLEN-1:0] wdata_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic [XLEN-1:0]   dcache_addr_o,
  output logic              dcache_read_en_o,
  output logic              dcache_write_en_o,
  output logic [XLEN-1:0]   dcache_write_data_o,
  input  logic [XLEN-1:0]   dcache_read_data_i
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_YIELD = HOLD_W'(MAX_HOLD - 2);

  arb_state_e        state;
  logic              owner;
  logic              last_winner;
  logic [HOLD_W-1:0] hold_cnt;

  logic              win_valid;
  logic              win_idx;
  logic              sel_we;
  logic [XLEN-1:0]   sel_addr;
  logic [XLEN-1:0]   sel_wdata;
  rd_tag_t           push_tag;
  rd_tag_t           pop_tag;

  // Pick this cycle's winner: a locked owner first, then round-robin on a
  // tie, else the lone requester. Nothing is granted while in reset.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = REQ_CORE;
    if (resetn_i) begin
      if (state == LOCKED && req_i[owner]) begin
        win_valid = 1'b1;
        win_idx   = owner;
      end else if (req_i[REQ_CORE] && req_i[REQ_AUX]) begin
        win_valid = 1'b1;
        win_idx   = ~last_winner;
      end else if (req_i[REQ_CORE]) begin
        win_valid = 1'b1;
        win_idx   = REQ_CORE;
      end else if (req_i[REQ_AUX]) begin
        win_valid = 1'b1;
        win_idx   = REQ_AUX;
      end
    end
  end

  // Route the winner's access fields to the dcache port.
  always_comb begin
    if (win_idx == REQ_AUX) begin
      sel_we    = we_i[REQ_AUX];
      sel_addr  = addr_i[2*XLEN-1:XLEN];
      sel_wdata = wdata_i[2*XLEN-1:XLEN];
    end else begin
      sel_we    = we_i[REQ_CORE];
      sel_addr  = addr_i[XLEN-1:0];
      sel_wdata = wdata_i[XLEN-1:0];
    end
  end

  assign gnt_o               = onehot2(win_valid, win_idx);
  assign dcache_read_en_o    = win_valid & ~sel_we;
  assign dcache_write_en_o   = win_valid & sel_we;
  assign dcache_addr_o       = win_valid ? sel_addr  : '0;
  assign dcache_write_data_o = win_valid ? sel_wdata : '0;

  // Arbitration state: lock ownership, hold counter and round-robin pointer.
  // The yield test uses MAX_HOLD-2 because the grant that enters LOCKED is
  // itself the first of the burst, so the yielding grant is the MAX_HOLD-th.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state       <= IDLE;
      owner       <= REQ_CORE;
      hold_cnt    <= '0;
      last_winner <= REQ_AUX;
    end else if (win_valid) begin
      last_winner <= win_idx;
      case (state)
        IDLE: begin
          if (lock_i[win_idx]) begin
            state    <= LOCKED;
            owner    <= win_idx;
            hold_cnt <= '0;
          end
        end
        LOCKED: begin
          if (win_idx != owner || !lock_i[owner] ||
              (req_i[~owner] && hold_cnt >= HOLD_YIELD)) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign push_tag.valid = win_valid & ~sel_we;
  assign push_tag.owner = win_idx;

  rd_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk_i),
    .clear   (~resetn_i),
    .push_tag(push_tag),
    .pop_tag (pop_tag)
  );

  assign rvalid_o = onehot2(pop_tag.valid & resetn_i, pop_tag.owner);
  assign rdata_o  = (|rvalid_o) ? dcache_read_data_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (RD_LAT 1, 2, 3, MAX_HOLD 16)
// share the same request inputs; each has its own latency-matched dcache model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic [1:0]  req    = '0;
  logic [1:0]  we     = '0;
  logic [1:0]  lock   = '0;
  logic [63:0] addr   = '0;
  logic [63:0] wdata  = '0;

  logic [1:0]  gnt     [3];
  logic [1:0]  rvalid  [3];
  logic [31:0] rdata   [3];
  logic [31:0] c_addr  [3];
  logic [31:0] c_wdata [3];
  logic [31:0] c_rd    [3];
  logic        c_ren   [3];
  logic        c_wen   [3];

  logic [31:0] mem [256];
  bit   [255:0] written;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    if (written[idx]) return mem[idx];
    case (a)
      32'h40:  return 32'hDEADBEEF;
      32'h44:  return 32'h12345678;
      32'h80:  return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (c_wen[0]) begin
      mem[c_addr[0][9:2]]     <= c_wdata[0];
      written[c_addr[0][9:2]] <= 1'b1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned LAT = k + 1;
    logic [31:0] pipe [LAT];

    dmem_arbiter #(
      .XLEN    (32),
      .RD_LAT  (LAT),
      .MAX_HOLD(16)
    ) u_dut (
      .clk_i              (clk),
      .resetn_i           (resetn),
      .req_i              (req),
      .we_i               (we),
      .lock_i             (lock),
      .addr_i             (addr),
      .wdata_i            (wdata),
      .gnt_o              (gnt[k]),
      .rvalid_o           (rvalid[k]),
      .rdata_o            (rdata[k]),
      .dcache_addr_o      (c_addr[k]),
      .dcache_read_en_o   (c_ren[k]),
      .dcache_write_en_o  (c_wen[k]),
      .dcache_write_data_o(c_wdata[k]),
      .dcache_read_data_i (c_rd[k])
    );

    always @(posedge clk) begin
      pipe[0] <= c_ren[k] ? rd_mem(c_addr[k]) : 32'h0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign c_rd[k] = pipe[LAT-1];
  end

  typedef struct {
    logic        rstn;
    logic [1:0]  req, we, lock;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  gnt;
    logic        ren, wen;
    logic [31:0] ca, cw;
    logic [1:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rstn, logic [1:0] rq, logic [1:0] w, logic [1:0] lk,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] g, logic ren, logic wen, logic [31:0] ca, logic [31:0] cw,
                              logic [1:0] rv, logic [31:0] rd);
    vec_t v;
    v.rstn = rstn; v.req = rq; v.we = w; v.lock = lk;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.gnt = g; v.ren = ren; v.wen = wen; v.ca = ca; v.cw = cw; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  // Packed layout: {gnt, read_en, write_en, addr, wdata, rvalid, rdata}
  function automatic logic [127:0] pk(logic [1:0] g, logic ren, logic wen, logic [31:0] ca,
                                      logic [31:0] cw, logic [1:0] rv, logic [31:0] rd);
    return {26'd0, g, ren, wen, ca, cw, rv, rd};
  endfunction

  function automatic logic [127:0] act(input int k);
    return pk(gnt[k], c_ren[k], c_wen[k], c_addr[k], c_wdata[k], rvalid[k], rdata[k]);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [1:0] rq, input logic [1:0] w,
                       input logic [1:0] lk, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    resetn = rn; req = rq; we = w; lock = lk;
    addr = {a1, a0}; wdata = {d1, d0};
    #2;
  endtask

  initial begin
    logic [1:0]  eg, erv, rq;
    logic [31:0] erd;
    int          iss;
    int          n1;

    //          rstn req    we     lock   a0      a1       d0 d1      gnt   ren  wen  ca       cw       rv     rd
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   0, 0,      2'b00, 0, 0, 32'h0,   32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 32'h40, 32'h0,   0, 0,      2'b00, 0, 0, 32'h0,   32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 32'h40, 32'h0,   0, 0,      2'b01, 1, 0, 32'h40,  32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   0, 0,      2'b00, 0, 0, 32'h0,   32'h0,   2'b01, 32'hDEADBEEF));
    tbl.push_back(mk(1, 2'b10, 2'b10, 2'b00, 32'h0,  32'h20,  0, 32'h55, 2'b10, 0, 1, 32'h20,  32'h55,  2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   0, 0,      2'b00, 0, 0, 32'h0,   32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b00, 32'h40, 32'h20,  0, 32'h55, 2'b01, 1, 0, 32'h40,  32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b10, 2'b10, 2'b00, 32'h0,  32'h20,  0, 32'h55, 2'b10, 0, 1, 32'h20,  32'h55,  2'b01, 32'hDEADBEEF));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 32'h20, 32'h0,   0, 0,      2'b01, 1, 0, 32'h20,  32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   0, 0,      2'b00, 0, 0, 32'h0,   32'h0,   2'b01, 32'h55));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b10, 32'h40, 32'h100, 0, 32'hA0, 2'b10, 0, 1, 32'h100, 32'hA0,  2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b10, 32'h40, 32'h104, 0, 32'hA1, 2'b10, 0, 1, 32'h104, 32'hA1,  2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b00, 32'h40, 32'h108, 0, 32'hA2, 2'b10, 0, 1, 32'h108, 32'hA2,  2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b00, 32'h40, 32'h10C, 0, 32'hA3, 2'b01, 1, 0, 32'h40,  32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b10, 2'b10, 2'b00, 32'h0,  32'h10C, 0, 32'hA3, 2'b10, 0, 1, 32'h10C, 32'hA3,  2'b01, 32'hDEADBEEF));
    tbl.push_back(mk(1, 2'b10, 2'b10, 2'b10, 32'h0,  32'h110, 0, 32'hB0, 2'b10, 0, 1, 32'h110, 32'hB0,  2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b11, 32'h40, 32'h114, 0, 32'hB1, 2'b10, 0, 1, 32'h114, 32'hB1,  2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b01, 32'h40, 32'h0,   0, 0,      2'b01, 1, 0, 32'h40,  32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b00, 32'h44, 32'h118, 0, 32'hB2, 2'b10, 0, 1, 32'h118, 32'hB2,  2'b01, 32'hDEADBEEF));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 32'h44, 32'h0,   0, 0,      2'b01, 1, 0, 32'h44,  32'h0,   2'b00, 32'h0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   0, 0,      2'b00, 0, 0, 32'h0,   32'h0,   2'b01, 32'h12345678));

    foreach (tbl[i]) begin
      drive(tbl[i].rstn, tbl[i].req, tbl[i].we, tbl[i].lock,
            tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("vec%0d", i), act(0),
          pk(tbl[i].gnt, tbl[i].ren, tbl[i].wen, tbl[i].ca, tbl[i].cw, tbl[i].rv, tbl[i].rd));
    end

    // Round-robin on a held tie after reset, returns checked at RD_LAT 1..3.
    drive(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rr_reset_state", act(2), 128'd0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, (c < 4) ? 2'b11 : 2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
        eg  = (c < 4) ? (((c % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
        iss = c - (k + 1);
        erv = 2'b00;
        erd = 32'h0;
        if (iss >= 0 && iss < 4) begin
          erv = ((iss % 2) == 0) ? 2'b01 : 2'b10;
          erd = ((iss % 2) == 0) ? 32'hDEADBEEF : 32'hCAFEF00D;
        end
        chk($sformatf("rr_gnt_c%0d_lat%0d", c, k + 1), 128'(gnt[k]), 128'(eg));
        chk($sformatf("rr_ret_c%0d_lat%0d", c, k + 1), 128'({rvalid[k], rdata[k]}), 128'({erv, erd}));
      end
    end

    // Locked write burst from requester 1 against a waiting read from requester 0.
    n1 = 0;
    for (int c = 0; c < 18; c++) begin
      rq = (c == 0) ? 2'b10 : 2'b11;
      drive(1'b1, rq, 2'b10, 2'b10, 32'h40, 32'h100 + 32'(4 * n1), 32'h0, 32'(n1));
      eg = (c == 16) ? 2'b01 : 2'b10;
      chk($sformatf("hold_gnt_c%0d", c), 128'(gnt[0]), 128'(eg));
      if (c == 16) chk("hold_yield_read", 128'({c_ren[0], c_addr[0]}), 128'({1'b1, 32'h40}));
      if (c == 17) chk("hold_yield_ret", 128'({rvalid[0], rdata[0]}), 128'({2'b01, 32'hDEADBEEF}));
      if (eg == 2'b10) n1++;
    end

    // Read issued, then one reset cycle: no late rvalid, outputs held at zero.
    drive(1'b1, 2'b01, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 32'h0);
    chk("rst_issue_gnt", 128'(gnt[1]), 128'(2'b01));
    drive(1'b0, 2'b11, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 32'h0);
    chk("rst_outputs_zero", act(1), 128'd0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst_no_rvalid_1", act(1), 128'd0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst_no_rvalid_2", act(1), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
